alu_ctl_exec: RTL and testbench

//  Consumer end of the 4-bit ALU control code (ALUCtl) interface: executes the decoded

---
 rtl/alu_ctl_exec.sv | 74 +++++++
 tb/tb_alu_ctl_exec.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_ctl_exec.sv
// alu_ctl_exec: two-stage valid/ready executor for 4-bit ALUCtl codes with zero/overflow/illegal flags
module alu_ctl_exec #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);
  localparam int M = WIDTH - 1;
  logic             v1;
  logic [3:0]       op1;
  logic [WIDTH-1:0] a1, b1, sum, dif, res;
  logic             s1_adv, s2_adv, legal, ovf;
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = v1 && s2_adv;
  assign in_ready = !flush && (!v1 || s2_adv);
  always_comb begin
    sum   = a1 + b1;
    dif   = a1 - b1;
    legal = op1 inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
    res   = op1 == 4'd0  ? a1 & b1 :
            op1 == 4'd1  ? a1 | b1 :
            op1 == 4'd2  ? sum :
            op1 == 4'd6  ? dif :
            op1 == 4'd7  ? {{M{1'b0}}, $signed(a1) < $signed(b1)} :
            op1 == 4'd12 ? ~(a1 | b1) : '0;
    ovf   = op1 == 4'd2 ? (a1[M] == b1[M] && sum[M] != a1[M]) :
            op1 == 4'd6 ? (a1[M] != b1[M] && dif[M] != a1[M]) : 1'b0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1         <= 1'b0;
      op1        <= '0;
      a1         <= '0;
      b1         <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      // a retire in the flush cycle still counts
      if (out_valid && out_ready && out_err && err_count != '1) err_count <= err_count + 1'b1;
      if (flush) begin
        v1        <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (in_ready) v1 <= in_valid;
        if (s2_adv) out_valid <= v1;
      end
      if (in_valid && in_ready) {op1, a1, b1} <= {in_op, in_a, in_b};
      if (s1_adv) begin
        out_result <= res;
        out_zero   <= res == '0;
        out_ovf    <= ovf;
        out_err    <= !legal;
      end
    end
  end
endmodule

// File: tb/tb_alu_ctl_exec.sv
// tb_alu_ctl_exec: scoreboard bench for alu_ctl_exec, with a CNT_W=2 twin for counter saturation
module tb_alu_ctl_exec;
  logic        clock, reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b, out_result, u2_result;
  logic        out_zero, out_ovf, out_err, u2_ready, u2_valid, u2_zero, u2_ovf, u2_err;
  logic [7:0]  err_count;
  logic [1:0]  u2_count;
  logic [34:0] q[$];
  int n_chk, n_pass, cnt, retired, stalls;

  alu_ctl_exec dut (.clock(clock), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_err(out_err), .err_count(err_count));
  alu_ctl_exec #(.WIDTH(32), .CNT_W(2)) u2 (.clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(u2_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(u2_valid), .out_ready(out_ready), .out_result(u2_result), .out_zero(u2_zero),
    .out_ovf(u2_ovf), .out_err(u2_err), .err_count(u2_count));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [34:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a), sb = $signed(b), t = 0;
    logic [31:0] r = '0;
    logic ov = 1'b0, er = 1'b0;
    case (o)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin t = sa + sb; r = t[31:0]; ov = t > 64'sd2147483647 || t < -64'sd2147483648; end
      4'd6:  begin t = sa - sb; r = t[31:0]; ov = t > 64'sd2147483647 || t < -64'sd2147483648; end
      4'd7:  r = {31'b0, sa < sb};
      4'd12: r = ~(a | b);
      default: er = 1'b1;
    endcase
    return {er, ov, r == 32'd0, r};
  endfunction

  always @(negedge clock) begin
    if (!reset_n) begin
      q.delete();
      cnt = 0;
    end else begin
      chk("err_count", err_count, cnt > 255 ? 255 : cnt);
      chk("err_count_sat", u2_count, cnt > 3 ? 3 : cnt);
      if (out_valid) begin
        chk("out_has_expect", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("result", out_result, q[0][31:0]);
          chk("zero", out_zero, q[0][32]);
          chk("ovf", out_ovf, q[0][33]);
          chk("err", out_err, q[0][34]);
          if (out_ready) begin
            if (q[0][34]) cnt++;
            void'(q.pop_front());
            retired++;
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b));
      if (flush) q.delete();
    end
  end

  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    int tries = 0;
    in_valid = 1'b1; in_op = o; in_a = a; in_b = b;
    do begin
      @(negedge clock);
      acc = in_ready;
      if (!acc) stalls++;
      @(posedge clock); #1;
      tries++;
    end while (!acc && tries < 20);
    chk("accept_timeout", acc, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int r0, acc;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0;
    @(posedge clock); #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_err_count", err_count, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clock); #1;
    // single ADD: registered into S1 at the accept edge, result valid after the next edge
    send(4'd2, 32'd5, 32'd7);
    in_valid = 1'b0;
    chk("lat_s1_only", out_valid, 0);
    @(posedge clock); #1;
    chk("lat_valid", out_valid, 1);
    chk("add_5_7", out_result, 12);
    idle(3);
    send(4'd2, 32'h7FFF_FFFF, 32'd1);
    send(4'd6, 32'h8000_0000, 32'd1);
    send(4'd7, 32'hFFFF_FFFF, 32'd1);
    send(4'd7, 32'd1, 32'hFFFF_FFFF);
    send(4'd6, 32'd3, 32'd3);
    idle(4);
    stalls = 0;
    r0 = retired;
    for (int i = 0; i < 8; i++)
      send(i % 2 ? 4'd12 : (i % 3 ? 4'd1 : 4'd0), $urandom, $urandom);
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("stream_stalls", stalls, 0);
    chk("stream_retired", retired - r0, 8);
    idle(2);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd2; in_a = 32'd100; in_b = 32'd23;
    acc = 0;
    r0 = retired;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (in_ready) acc++;
      @(posedge clock); #1 in_a = in_a + 32'd1;
    end
    @(negedge clock);
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready", in_ready, 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("bp_retired", retired - r0, 2);
    send(4'd3, 32'd1, 32'd2);
    send(4'd15, 32'd3, 32'd4);
    send(4'd15, 32'hFFFF_FFFF, 32'd0);
    idle(3);
    chk("errcnt_3", err_count, 3);
    send(4'd4, 32'd5, 32'd6);
    send(4'd9, 32'd7, 32'd8);
    idle(3);
    chk("errcnt_5", err_count, 5);
    chk("errcnt_sat_2b", u2_count, 3);
    out_ready = 1'b0;
    r0 = retired;
    send(4'd0, 32'hF0F0, 32'hFF00);
    send(4'd1, 32'h1234, 32'h8000);
    in_valid = 1'b1; in_op = 4'd2; in_a = 32'd1; in_b = 32'd1; flush = 1'b1;
    @(negedge clock);
    chk("flush_in_ready", in_ready, 0);
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    out_ready = 1'b1;
    idle(3);
    chk("flush_no_retire", retired - r0, 0);
    chk("flush_keeps_count", err_count, 5);
    out_ready = 1'b0;
    send(4'd2, 32'd9, 32'd9);
    send(4'd5, 32'd1, 32'd1);
    idle(1);
    chk("pre_rst_valid", out_valid, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_result", out_result, 0);
    chk("arst_flags", {out_zero, out_ovf, out_err}, 0);
    chk("arst_err_count", err_count, 0);
    repeat (2) @(negedge clock);
    @(posedge clock); #1 reset_n = 1'b1;
    out_ready = 1'b1;
    r0 = retired;
    @(negedge clock);
    chk("post_rst_ready", in_ready, 1);
    idle(3);
    chk("post_rst_no_retire", retired - r0, 0);
    chk("drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
